vga_text_ctrl: RTL and testbench

//  Text-mode display controller: tracks character cell position from the VGA timing stream and owns the character/attribute buffer.

---
 rtl/vga_text_ctrl_if.sv | 22 ++
 rtl/vga_text_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_ctrl_if.sv
// CPU access port of the text controller's character/attribute buffer.
// The CPU side holds cpu_req until it sees the single-cycle cpu_ack.
interface vga_text_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vga_text_ctrl.sv
// Text-mode VGA controller: follows the timing stream to find the current
// character cell, fetches the cell entry from the single-port text buffer,
// drives the 1-cycle glyph ROM and emits RGB444 three cycles after input.
// The CPU shares the buffer port and only wins on non-fetch cycles.
module vga_text_ctrl #(
  parameter int COLS         = 20,
  parameter int ROWS         = 13,
  parameter int GLYPH_H      = 36,
  parameter int ADDR_W       = 9,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic [11:0] rgb,
  output logic [11:0] rom_addr,
  output logic [6:0]  rom_font_type,
  input  logic        rom_rdata,
  vga_text_ctrl_if.slave cpu
);

  localparam int ENTRIES = COLS * ROWS;
  localparam int XW      = 5;                       // glyph is 32 pixels wide
  localparam int CW      = $clog2(COLS + 1);        // col may sit at COLS past the last cell
  localparam int YW      = $clog2(GLYPH_H);
  localparam int RW      = $clog2(ROWS + 1);        // row parks at ROWS below the text area
  localparam int FW      = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0]     COLS_C   = CW'(COLS);
  localparam logic [RW-1:0]     ROWS_C   = RW'(ROWS);
  localparam logic [YW-1:0]     YLAST_C  = YW'(GLYPH_H - 1);
  localparam logic [FW-1:0]     FLAST_C  = FW'(BLINK_FRAMES - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  // Character/attribute buffer; contents survive reset.
  logic [15:0] text_mem [ENTRIES];

  // Position and frame state
  logic           de_prev_q, de_prev_d;
  logic           vs_prev_q, vs_prev_d;
  logic [XW-1:0]  xin_q, xin_d;
  logic [CW-1:0]  col_q, col_d;
  logic [YW-1:0]  yin_q, yin_d;
  logic [RW-1:0]  row_q, row_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic           hide_q, hide_d;

  // Render pipeline
  logic [15:0]    attr_q, attr_d;       // entry of the cell whose ROM read is in flight
  logic [8:0]     attr2_q, attr2_d;     // {bg, fg, blink} aligned with rom_rdata
  logic [11:0]    rom_addr_q, rom_addr_d;
  logic [1:0]     vis_pipe_q, vis_pipe_d;
  logic [2:0]     de_pipe_q, de_pipe_d;
  logic [2:0]     hs_pipe_q, hs_pipe_d;
  logic [2:0]     vs_pipe_q, vs_pipe_d;
  logic [11:0]    rgb_q, rgb_d;

  // CPU port
  logic           ack_q, ack_d;
  logic [15:0]    rdata_q, rdata_d;

  // Combinational helpers
  logic              fetch, vis, grant, in_range, buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [15:0]       buf_rd;
  logic              px_on;
  logic [3:0]        px_col;

  function automatic logic [11:0] expand(input logic [3:0] c);
    logic [3:0] lvl;
    lvl = c[3] ? 4'hF : 4'hA;
    return {c[2] ? lvl : 4'h0, c[1] ? lvl : 4'h0, c[0] ? lvl : 4'h0};
  endfunction

  // Buffer port arbitration and asynchronous buffer read
  always_comb begin
    vis      = de_in & (row_q < ROWS_C);
    fetch    = vis & (xin_q == '0) & (col_q < COLS_C);
    in_range = int'(cpu.cpu_addr) < ENTRIES;
    // The ack cycle is excluded so a still-held request is not served twice.
    grant    = cpu.cpu_req & ~fetch & ~ack_q & ~rst;
    buf_addr = fetch ? (ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q)) : cpu.cpu_addr;
    buf_we   = grant & cpu.cpu_we & in_range;
    buf_rd   = text_mem[buf_addr];
  end

  // Buffer write port (CPU writes land at the grant edge)
  always_ff @(posedge clk) begin
    if (buf_we) text_mem[buf_addr] <= cpu.cpu_wdata;
  end

  // Next-state logic for counters, pipeline and CPU response
  always_comb begin
    de_prev_d  = de_in;
    vs_prev_d  = vs_in;
    xin_d      = '0;
    col_d      = '0;
    yin_d      = yin_q;
    row_d      = row_q;
    frame_d    = frame_q;
    hide_d     = hide_q;
    attr_d     = attr_q;
    rom_addr_d = rom_addr_q;

    // Horizontal position: only advances while de_in is high.
    if (de_in) begin
      xin_d = xin_q + 1'b1;
      col_d = col_q;
      if (xin_q == '1 && col_q < COLS_C) col_d = col_q + 1'b1;
    end

    // Vertical position: one step per line end; vsync realigns to the top.
    if (vs_in) begin
      yin_d = '0;
      row_d = '0;
    end else if (de_prev_q && !de_in) begin
      if (yin_q == YLAST_C) begin
        yin_d = '0;
        if (row_q < ROWS_C) row_d = row_q + 1'b1;
      end else begin
        yin_d = yin_q + 1'b1;
      end
    end

    // Blink phase toggles every BLINK_FRAMES vsync rising edges.
    if (vs_in && !vs_prev_q) begin
      if (frame_q == FLAST_C) begin
        frame_d = '0;
        hide_d  = ~hide_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // Stage 1: cell entry and ROM address; both hold outside the text area.
    if (fetch) attr_d = buf_rd;
    if (vis)   rom_addr_d = 12'({yin_q, xin_q});

    // Stage 2: colour select once the glyph bit is back.
    attr2_d    = attr_q[15:7];
    px_on      = rom_rdata & ~(attr2_q[0] & hide_q);
    px_col     = px_on ? attr2_q[4:1] : attr2_q[8:5];
    rgb_d      = vis_pipe_q[1] ? expand(px_col) : 12'h000;

    vis_pipe_d = {vis_pipe_q[0], vis};
    de_pipe_d  = {de_pipe_q[1:0], de_in};
    hs_pipe_d  = {hs_pipe_q[1:0], hs_in};
    vs_pipe_d  = {vs_pipe_q[1:0], vs_in};

    ack_d      = grant;
    rdata_d    = (grant && !cpu.cpu_we && in_range) ? buf_rd : 16'h0000;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      de_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      xin_q      <= '0;
      col_q      <= '0;
      yin_q      <= '0;
      row_q      <= '0;
      frame_q    <= '0;
      hide_q     <= 1'b0;
      attr_q     <= '0;
      attr2_q    <= '0;
      rom_addr_q <= '0;
      vis_pipe_q <= '0;
      de_pipe_q  <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      rgb_q      <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      de_prev_q  <= de_prev_d;
      vs_prev_q  <= vs_prev_d;
      xin_q      <= xin_d;
      col_q      <= col_d;
      yin_q      <= yin_d;
      row_q      <= row_d;
      frame_q    <= frame_d;
      hide_q     <= hide_d;
      attr_q     <= attr_d;
      attr2_q    <= attr2_d;
      rom_addr_q <= rom_addr_d;
      vis_pipe_q <= vis_pipe_d;
      de_pipe_q  <= de_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      rgb_q      <= rgb_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign de_out        = de_pipe_q[2];
  assign hs_out        = hs_pipe_q[2];
  assign vs_out        = vs_pipe_q[2];
  assign rgb           = rgb_q;
  assign rom_addr      = rom_addr_q;
  assign rom_font_type = attr_q[6:0];
  assign cpu.cpu_ack   = ack_q;
  assign cpu.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl: a reference model of the text display predicts
// every output cycle into a queue that a negedge monitor drains.
module tb_vga_text_ctrl;
  localparam int COLS = 20;
  localparam int ROWS = 13;
  localparam int GH   = 36;
  localparam int AW   = 9;
  localparam int BF   = 2;
  localparam int NPX  = 64;   // short lines: two character columns
  localparam int ENT  = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic        de_out, hs_out, vs_out;
  logic [11:0] rgb, rom_addr;
  logic [6:0]  rom_font_type;
  logic        rom_rdata = 1'b0;

  vga_text_ctrl_if #(.ADDR_W(AW)) cpu ();

  vga_text_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .GLYPH_H(GH), .ADDR_W(AW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .rgb(rgb), .rom_addr(rom_addr), .rom_font_type(rom_font_type),
    .rom_rdata(rom_rdata),
    .cpu(cpu)
  );

  always #5 clk = ~clk;

  // Glyph ROM model: 1-cycle registered lookup
  function automatic logic glyph(input logic [6:0] code, input logic [11:0] a);
    return a[0] ^ a[6] ^ code[0];
  endfunction

  always @(posedge clk) rom_rdata <= glyph(rom_font_type, rom_addr);

  function automatic logic [11:0] cexp(input logic [3:0] c);
    logic [11:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++)
      if (c[2-ch]) r[11-4*ch -: 4] = c[3] ? 4'hF : 4'hA;
    return r;
  endfunction

  int npass = 0;
  int nchk  = 0;
  logic mon_en = 1'b0;
  logic [14:0] sbq [$];

  logic [15:0] shadow [0:ENT-1];
  int   mx, my, mframe;
  logic mde_prev, mvs_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Output monitor: every cycle pops one predicted {de,hs,vs,rgb}
  always @(negedge clk) begin
    if (mon_en) begin
      nchk++;
      assert (sbq.size() != 0) npass++;
      else $error("FAIL sb_empty: got 0 entries expected >=1 at %0t", $time);
      if (sbq.size() != 0) chk("video", {de_out, hs_out, vs_out, rgb}, sbq.pop_front());
    end
  end

  task automatic restart_model();
    sbq.delete();
    mx = 0; my = 0; mframe = 0; mde_prev = 1'b0; mvs_prev = 1'b0;
    repeat (3) sbq.push_back(15'h0);
    mon_en = 1'b1;
  endtask

  // Drive one pixel cycle and predict its output
  task automatic drive(input logic de, input logic hs, input logic vs);
    logic [15:0] ent;
    logic [11:0] e;
    int a;
    de_in = de; hs_in = hs; vs_in = vs;
    e = 12'h000;
    if (de && my < ROWS * GH) begin
      ent = shadow[(my / GH) * COLS + mx / 32];
      a   = (my % GH) * 32 + (mx % 32);
      if (glyph(ent[6:0], 12'(a)) && !(ent[7] && ((mframe / BF) % 2 == 1)))
        e = cexp(ent[11:8]);
      else
        e = cexp(ent[15:12]);
    end
    sbq.push_back({de, hs, vs, e});
    if (de) mx++; else mx = 0;
    if (mde_prev && !de) my++;
    if (vs) my = 0;
    if (vs && !mvs_prev) mframe++;
    mde_prev = de; mvs_prev = vs;
    @(posedge clk); #1;
  endtask

  task automatic vsync();
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // One line; cx >= 0 adds ROM checks at pixel cx and rgb checks for cx, cx+1
  task automatic line(input int cx, input logic [11:0] ea, input logic [6:0] ef,
                      input logic [11:0] e0, input logic [11:0] e1);
    for (int i = 0; i < NPX; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (cx >= 0 && i == cx) begin
        chk("rom_addr", rom_addr, ea);
        chk("rom_type", rom_font_type, ef);
      end
      if (cx >= 0 && i == cx + 2) chk("rgb_px0", rgb, e0);
      if (cx >= 0 && i == cx + 3) chk("rgb_px1", rgb, e1);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // CPU access with request held through the ack cycle
  task automatic cpu_op(input logic we, input int addr, input logic [15:0] wdata,
                        input logic [15:0] exp);
    cpu.cpu_req = 1'b1; cpu.cpu_we = we;
    cpu.cpu_addr = AW'(addr); cpu.cpu_wdata = wdata;
    drive(1'b0, 1'b0, 1'b0);
    chk("cpu_ack", cpu.cpu_ack, 1);
    if (!we) chk("cpu_rdata", cpu.cpu_rdata, exp);
    drive(1'b0, 1'b0, 1'b0);
    chk("cpu_ack_once", cpu.cpu_ack, 0);
    cpu.cpu_req = 1'b0;
    if (we && addr < ENT) shadow[addr] = wdata;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int k;
    cpu.cpu_req = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_addr = '0; cpu.cpu_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    restart_model();

    // Buffer write then read-back with no video
    cpu_op(1'b1, 0, 16'h2F41, 16'h0);
    cpu_op(1'b0, 0, 16'h0, 16'h2F41);
    cpu_op(1'b1, 1, 16'h2F42, 16'h0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 2; c++) begin
        k = r * 2 + c;
        v = {4'(k), 4'(15 - (k % 16)), (k % 5 == 3), 7'(7'h30 + k)};
        if (k > 1) cpu_op(1'b1, r * COLS + c, v, 16'h0);
      end

    // Glyph sequencing: rom address/type and lit/unlit colours
    vsync();
    line(0, 12'd0, 7'h41, 12'hFFF, 12'h0A0);
    line(37, 12'd37, 7'h42, 12'hFFF, 12'h0A0);

    // CPU read raised on a fetch cycle during active video
    vsync();
    for (int i = 0; i < NPX; i++) begin
      if (i == 32) begin
        cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_addr = AW'(20);
      end
      drive(1'b1, 1'b0, 1'b0);
      if (i == 32) chk("ack_defer", cpu.cpu_ack, 0);
      if (i == 33) begin
        chk("ack_late", cpu.cpu_ack, 1);
        chk("rdata_late", cpu.cpu_rdata, shadow[20]);
        cpu.cpu_req = 1'b0;
      end
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    // Blinking cell across six short frames
    cpu_op(1'b1, 0, 16'h2FC1, 16'h0);
    repeat (6) begin
      vsync();
      line(-1, 12'd0, 7'h0, 12'h0, 12'h0);
      line(-1, 12'd0, 7'h0, 12'h0, 12'h0);
    end

    // Full-height frame: bottom band blank, ROM outputs hold
    vsync();
    for (int l = 0; l < 480; l++) begin
      line(-1, 12'd0, 7'h0, 12'h0, 12'h0);
      if (l == 470) begin
        chk("rom_hold_addr", rom_addr, 12'd1151);
        chk("rom_hold_type", rom_font_type, shadow[12 * COLS + 1][6:0]);
      end
    end
    cpu_op(1'b1, 300, 16'hBEEF, 16'h0);
    cpu_op(1'b0, 300, 16'h0, 16'h0000);
    cpu_op(1'b0, 0, 16'h0, 16'h2FC1);

    // Reset in the middle of a line with a CPU request pending
    vsync();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0);
    cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_addr = AW'(5);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_de", de_out, 0);
    chk("rst_hs", hs_out, 0);
    chk("rst_vs", vs_out, 0);
    chk("rst_ack", cpu.cpu_ack, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_type", rom_font_type, 0);
    @(posedge clk); #1;
    rst = 1'b0; de_in = 1'b0; cpu.cpu_req = 1'b0;
    restart_model();
    drive(1'b0, 1'b0, 1'b0);
    chk("rst_req_dropped", cpu.cpu_ack, 0);
    vsync();
    line(0, 12'd0, 7'h41, 12'hFFF, 12'h0A0);
    line(-1, 12'd0, 7'h0, 12'h0, 12'h0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
